// File: rtl/regfile_bist_pkg.sv
// Shared types, defaults and the test-pattern generator for the register-file self-test master.
package regfile_bist_pkg;

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} bistState_e;

  localparam int DEF_AW    = 5;
  localparam int DEF_DW    = 32;
  localparam int DEF_NREGS = 32;
  localparam int ERR_W     = 8;
  localparam logic [31:0] DEF_SEED = 32'hA5C3_0F5A;

  // Each byte lane of the address is folded into the seed so neighbouring registers differ in every byte.
  function automatic logic [31:0] pattern(input logic [31:0] seed, input logic [31:0] addr,
                                          input logic inv);
    logic [31:0] p;
    p = seed ^ (addr * 32'h0101_0101);
    return inv ? ~p : p;
  endfunction

endpackage

// File: rtl/regfile_bist_cmp.sv
// Read-back comparator and saturating error accumulator for regfile_bist.
module regfile_bist_cmp
  import regfile_bist_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [DW-1:0]    rd1,
  input  logic [DW-1:0]    rd2,
  input  logic [DW-1:0]    exp1,
  input  logic [DW-1:0]    exp2,
  input  logic             sameAddr,
  input  logic [AW-1:0]    ra1,
  input  logic [AW-1:0]    ra2,
  output logic [ERR_W-1:0] err_count,
  output logic [AW-1:0]    fail_addr
);

  logic           miss1;
  logic           miss2;
  logic [ERR_W:0] sum;

  // On the final odd pair both ports address the same register, so only port 1 is judged.
  always_comb begin
    miss1 = enable && (rd1 != exp1);
    miss2 = enable && !sameAddr && (rd2 != exp2);
    sum   = {1'b0, err_count} + (ERR_W+1)'(miss1) + (ERR_W+1)'(miss2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
      fail_addr <= '0;
    end else if (clear) begin
      err_count <= '0;
      fail_addr <= '0;
    end else if (miss1 || miss2) begin
      err_count <= sum[ERR_W] ? '1 : sum[ERR_W-1:0];
      if (err_count == '0) begin
        fail_addr <= miss1 ? ra1 : ra2;
      end
    end
  end

endmodule

// File: rtl/regfile_bist.sv
// Power-on self-test master for the 3-port register file: write/read-back with a pattern and its inverse.
// Optional macro REGFILE_BIST_ZERO_CHECK_EN adds a write to and a zero read-back of register 0 each pass.
module regfile_bist
  import regfile_bist_pkg::*;
#(
  parameter int          AW    = DEF_AW,
  parameter int          DW    = DEF_DW,
  parameter int          NREGS = DEF_NREGS,
  parameter logic [31:0] SEED  = DEF_SEED
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [AW-1:0]    fail_addr,
  output logic [ERR_W-1:0] err_count,
  output logic             we3,
  output logic [AW-1:0]    wa3,
  output logic [DW-1:0]    wd3,
  output logic [AW-1:0]    ra1,
  output logic [AW-1:0]    ra2,
  input  logic [DW-1:0]    rd1,
  input  logic [DW-1:0]    rd2
);

  localparam logic [AW-1:0] LAST      = AW'(NREGS - 1);
  localparam logic [AW-1:0] LAST_PAIR = AW'(NREGS - 2);
  localparam logic [AW-1:0] FIRST_RD  = AW'(1);
`ifdef REGFILE_BIST_ZERO_CHECK_EN
  localparam logic [AW-1:0] FIRST_WR  = '0;
`else
  localparam logic [AW-1:0] FIRST_WR  = AW'(1);
`endif

  bistState_e    state, stateNext;
  logic [AW-1:0] addr, addrNext;
  logic          inv, invNext;
  logic          clearErr;
  logic          passEnd;
  logic [AW-1:0] partnerNext;
  logic [DW-1:0] exp1, exp2;

  // Next-state sequencing; address 0 inside READ marks the optional zero-check cycle.
  always_comb begin
    stateNext = state;
    addrNext  = addr;
    invNext   = inv;
    clearErr  = 1'b0;
    passEnd   = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          stateNext = WRITE;
          addrNext  = FIRST_WR;
          invNext   = 1'b0;
          clearErr  = 1'b1;
        end
      end
      WRITE: begin
        if (addr == LAST) begin
          stateNext = READ;
          addrNext  = FIRST_RD;
        end else begin
          addrNext = addr + AW'(1);
        end
      end
      READ: begin
`ifdef REGFILE_BIST_ZERO_CHECK_EN
        if (addr == '0) passEnd = 1'b1;
        else if (addr >= LAST_PAIR) addrNext = '0;
`else
        if (addr >= LAST_PAIR) passEnd = 1'b1;
`endif
        else addrNext = addr + AW'(2);
        if (passEnd) begin
          if (!inv) begin
            stateNext = WRITE;
            addrNext  = FIRST_WR;
            invNext   = 1'b1;
          end else begin
            stateNext = DONE;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
    partnerNext = (addrNext == '0) ? '0 : ((addrNext >= LAST) ? LAST : addrNext + AW'(1));
  end

  // Bus outputs are loaded alongside the state so they line up with the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      addr  <= '0;
      inv   <= 1'b0;
      we3   <= 1'b0;
      wa3   <= '0;
      wd3   <= '0;
      ra1   <= '0;
      ra2   <= '0;
    end else begin
      state <= stateNext;
      addr  <= addrNext;
      inv   <= invNext;
      we3   <= (stateNext == WRITE);
      wa3   <= (stateNext == WRITE) ? addrNext : '0;
      wd3   <= (stateNext == WRITE) ? DW'(pattern(SEED, 32'(addrNext), invNext)) : '0;
      ra1   <= (stateNext == READ) ? addrNext : '0;
      ra2   <= (stateNext == READ) ? partnerNext : '0;
    end
  end

  always_comb begin
    exp1 = (ra1 == '0) ? '0 : DW'(pattern(SEED, 32'(ra1), inv));
    exp2 = DW'(pattern(SEED, 32'(ra2), inv));
    busy = (state == WRITE) || (state == READ);
    done = (state == DONE);
    pass = done && (err_count == '0);
  end

  regfile_bist_cmp #(.AW(AW), .DW(DW)) cmp (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clearErr),
    .enable   (state == READ),
    .rd1      (rd1),
    .rd2      (rd2),
    .exp1     (exp1),
    .exp2     (exp2),
    .sameAddr (ra1 == ra2),
    .ra1      (ra1),
    .ra2      (ra2),
    .err_count(err_count),
    .fail_addr(fail_addr)
  );

endmodule

// File: tb/tb_regfile_bist.sv
// Directed bench for regfile_bist with a behavioural register file that can inject faults.
// Honours REGFILE_BIST_ZERO_CHECK_EN for cycle counts and the writable-register-0 case.
module tb_regfile_bist;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, pass, we3;
  logic [4:0]  fail_addr, wa3, ra1, ra2;
  logic [7:0]  err_count;
  logic [31:0] wd3, rd1, rd2;

  logic [31:0] mem [32];
  logic [31:0] wrVal;
  int          faultMode = 0;
  int          testsRun = 0;
  int          testsFailed = 0;
  int          cycles, maxStep, guard;
  logic        sampledWe;
  logic [4:0]  sampledWa;
  logic [31:0] sampledWd;

`ifdef REGFILE_BIST_ZERO_CHECK_EN
  localparam int EXP_CYCLES = 98;
  localparam int WR5_AT     = 5;
`else
  localparam int EXP_CYCLES = 94;
  localparam int WR5_AT     = 4;
`endif

  regfile_bist dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .pass(pass),
    .fail_addr(fail_addr), .err_count(err_count), .we3(we3), .wa3(wa3), .wd3(wd3),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] tbPattern(input logic [31:0] a, input logic inv);
    logic [31:0] p;
    p = 32'hA5C3_0F5A ^ (a * 32'h0101_0101);
    return inv ? ~p : p;
  endfunction

  // Mode 1: bit 3 of reg 7 stuck at 0. Mode 3: regs 9 and 10 corrupted on the first-pass pattern.
  always @(posedge clk) begin
    if (we3) begin
      wrVal = wd3;
      if (faultMode == 1 && wa3 == 5'd7) wrVal[3] = 1'b0;
      if (faultMode == 3 && (wa3 == 5'd9 || wa3 == 5'd10) && wd3 == tbPattern(32'(wa3), 1'b0))
        wrVal = wrVal ^ 32'h1;
      mem[wa3] <= wrVal;
    end
  end

  // Mode 2: every register reads zero. Mode 4: register 0 behaves like an ordinary register.
  always_comb begin
    rd1 = mem[ra1];
    rd2 = mem[ra2];
    if (faultMode == 2) begin
      rd1 = '0;
      rd2 = '0;
    end
    if (ra1 == 5'd0 && faultMode != 4) rd1 = '0;
    if (ra2 == 5'd0 && faultMode != 4) rd2 = '0;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int mode, input bit pulseWhileBusy);
    int prev;
    faultMode = mode;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("busyAfterStart", 32'(busy), 32'd1);
    checkOutput("doneClearedOnStart", 32'(done), 32'd0);
    cycles  = 0;
    maxStep = 0;
    prev    = int'(err_count);
    while (!done && cycles < 500) begin
      @(posedge clk);
      #1;
      cycles++;
      if (cycles == WR5_AT) begin
        sampledWe = we3;
        sampledWa = wa3;
        sampledWd = wd3;
      end
      if (int'(err_count) - prev > maxStep) maxStep = int'(err_count) - prev;
      prev  = int'(err_count);
      start = pulseWhileBusy && (cycles == 10 || cycles == 50);
    end
    start = 1'b0;
    checkOutput("doneReached", 32'(done), 32'd1);
  endtask

  initial begin
    #3;
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstDone", 32'(done), 32'd0);
    checkOutput("rstPass", 32'(pass), 32'd0);
    checkOutput("rstErr", 32'(err_count), 32'd0);
    checkOutput("rstWe3", 32'(we3), 32'd0);
    checkOutput("rstWd3", wd3, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(0, 1'b0);
    checkOutput("healthyCycles", 32'(cycles), 32'(EXP_CYCLES));
    checkOutput("healthyPass", 32'(pass), 32'd1);
    checkOutput("healthyErr", 32'(err_count), 32'd0);
    checkOutput("healthyFailAddr", 32'(fail_addr), 32'd0);
    checkOutput("write5We", 32'(sampledWe), 32'd1);
    checkOutput("write5Wa", 32'(sampledWa), 32'd5);
    checkOutput("write5Wd", sampledWd, 32'hA0C6_0A5F);
    checkOutput("doneBusyLow", 32'(busy), 32'd0);
    checkOutput("doneWe3Low", 32'(we3), 32'd0);

    applyStimulus(1, 1'b0);
    checkOutput("stuckErr", 32'(err_count), 32'd1);
    checkOutput("stuckFailAddr", 32'(fail_addr), 32'd7);
    checkOutput("stuckPass", 32'(pass), 32'd0);

    applyStimulus(2, 1'b0);
    checkOutput("zeroRegsErr", 32'(err_count), 32'd62);
    checkOutput("zeroRegsFailAddr", 32'(fail_addr), 32'd1);

    applyStimulus(3, 1'b0);
    checkOutput("pairErr", 32'(err_count), 32'd2);
    checkOutput("pairStep", 32'(maxStep), 32'd2);
    checkOutput("pairFailAddr", 32'(fail_addr), 32'd9);

    // Abort mid-write and confirm everything falls back without waiting for a clock edge.
    faultMode = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    guard = 0;
    while (!(we3 && wa3 == 5'd12) && guard < 60) begin
      @(posedge clk);
      #1;
      guard++;
    end
    checkOutput("reachedWrite12", 32'(we3 && wa3 == 5'd12), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abortWe3", 32'(we3), 32'd0);
    checkOutput("abortBusy", 32'(busy), 32'd0);
    checkOutput("abortDone", 32'(done), 32'd0);
    checkOutput("abortWa3", 32'(wa3), 32'd0);
    checkOutput("abortWd3", wd3, 32'd0);
    checkOutput("abortRa", 32'({ra1, ra2}), 32'd0);
    checkOutput("abortErr", 32'(err_count), 32'd0);
    checkOutput("abortFailAddr", 32'(fail_addr), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(0, 1'b1);
    checkOutput("restartCycles", 32'(cycles), 32'(EXP_CYCLES));
    checkOutput("restartPass", 32'(pass), 32'd1);

`ifdef REGFILE_BIST_ZERO_CHECK_EN
    applyStimulus(4, 1'b0);
    checkOutput("zeroRegCycles", 32'(cycles), 32'd98);
    checkOutput("zeroRegErr", 32'(err_count), 32'd2);
    checkOutput("zeroRegFailAddr", 32'(fail_addr), 32'd0);
    checkOutput("zeroRegPass", 32'(pass), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
